irrigation_zone_scheduler: RTL and testbench
============================================

Name: irrigation_zone_scheduler

Overview:
- Shares the single 30-0 BCD countdown timer among ZONES irrigation zones.
- Grants zones round-robin, loads the timer with a per-zone watering time, and drives that zone's valve until the timer expires.
- After each watering it loads a settling pause.
- Sits between the soil-sensor inputs and the countdown/valve datapath, in the _50_MHz domain.

Parameters:
- ZONES, 4: number of zones; 2..4 supported.
- SPRAY_TIME, 30: watering seconds for sprinkler zones; binary, 1..39.
- DRIP_TIME, 15: watering seconds for drip zones; binary, 1..39.
- PAUSE_TIME, 5: inter-zone pause seconds; binary, 1..39.

Ports:
- _50_MHz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global irrigation enable (level)
- zone_req  in  ZONES  per-zone dry request (level, already synchronous)
- zone_drip  in  ZONES  1 = zone uses DRIP_TIME, 0 = SPRAY_TIME
- timer_done  in  1  time_over level from the shared countdown
- timer_load  out  1  one-cycle pulse: countdown must load timer_preset
- timer_preset  out  6  BCD preset {tens[1:0], units[3:0]}
- valve  out  ZONES  one-hot valve drive
- active_zone  out  2  index of the granted zone
- state  out  2  0 IDLE, 1 LOAD, 2 WATER, 3 PAUSE
- busy  out  1  state != IDLE
- cycle_done  out  1  one-cycle pulse on PAUSE -> IDLE

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE; valve, timer_load, timer_preset, active_zone, busy and cycle_done = 0.
  - last_grant = ZONES-1, so zone 0 is checked first.
  - done_q (timer_done delay register) = 0.
  - Reset mid-operation closes valves immediately, without waiting for a clock edge.
- done_rise = timer_done & ~done_q. Only rising edges end a timed phase; a stale high time_over after a load is ignored.
- IDLE:
  - If enable and zone_req != 0, search zones last_grant+1 .. last_grant+ZONES, wrapping modulo ZONES; the first requester wins.
  - Latch it into active_zone and last_grant.
  - Set timer_preset = BCD(zone_drip[winner] ? DRIP_TIME : SPRAY_TIME); go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - timer_load = 1; go to WATER.
  - The valve opens in WATER, so it opens 2 cycles after the grant.
- WATER:
  - valve = one-hot(active_zone).
  - On done_rise: set timer_preset = BCD(PAUSE_TIME), pulse timer_load for 1 cycle, go to PAUSE.
  - The valve is 0 from the first PAUSE cycle.
- PAUSE:
  - Valves off.
  - On done_rise: go to IDLE and pulse cycle_done for 1 cycle.
  - A new grant is possible on the following IDLE cycle.
- enable = 0 in LOAD, WATER or PAUSE:
  - Next cycle: state = IDLE, valve = 0, no timer_load, no cycle_done.
  - last_grant keeps the aborted zone.
  - enable = 0 has priority over a simultaneous done_rise.
- zone_req of the granted zone dropping during WATER: ignored; the zone waters for its full time (see optional feature).
- timer_load is asserted only in the LOAD cycle and the WATER -> PAUSE transition cycle, never 2 cycles in a row.
- BCD conversion: tens = sec / 10, units = sec % 10; done combinationally on constants or a 6-bit value, then registered.
- At most one valve bit is ever set.

Optional Feature:
- Macro: EARLY_STOP_EN.
- Defined: in WATER, if zone_req[active_zone] = 0 for a cycle, treat it like done_rise. Load PAUSE_TIME, pulse timer_load, go to PAUSE. enable = 0 still takes priority.
- Undefined: zone_req is sampled only in IDLE; watering always runs its full time.

Test Plan:
- Reset then zone_req = 4'b0001, zone_drip = 0, enable = 1. Required:
  - state goes IDLE -> LOAD -> WATER.
  - timer_load pulses 1 cycle with timer_preset = 6'b11_0000 (30).
  - valve = 0001 from cycle 2.
  - Model done_rise: PAUSE with preset 6'b00_0101 and valve = 0.
  - Second done_rise: cycle_done pulse, then IDLE.
- zone_req = 4'b1111 held over 5 full cycles -> active_zone sequence 0, 1, 2, 3, 0.
- zone_drip[2] = 1, only zone 2 requesting -> timer_preset = 6'b01_0101 (15).
- timer_done held high through LOAD and WATER -> no transition until it falls and rises again.
- enable dropped mid-WATER, in the same cycle as a done_rise -> next cycle IDLE, valve = 0, no timer_load, no cycle_done. Re-enable -> next grant is last_grant+1.
- Assert reset_n = 0 mid-WATER -> valve = 0 with no clock edge. With EARLY_STOP_EN defined, drop zone_req mid-WATER -> PAUSE next cycle with a timer_load pulse.

Source files
------------

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin scheduler sharing one BCD countdown timer among ZONES irrigation zones.
// Optional `EARLY_STOP_EN: a granted zone dropping its request ends watering early.
module irrigation_zone_scheduler #(
  parameter int ZONES      = 4,
  parameter int SPRAY_TIME = 30,
  parameter int DRIP_TIME  = 15,
  parameter int PAUSE_TIME = 5
) (
  input  logic             _50_MHz,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ZONES-1:0] zone_req,
  input  logic [ZONES-1:0] zone_drip,
  input  logic             timer_done,
  output logic             timer_load,
  output logic [5:0]       timer_preset,
  output logic [ZONES-1:0] valve,
  output logic [1:0]       active_zone,
  output logic [1:0]       state,
  output logic             busy,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WATER = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  function automatic logic [5:0] to_bcd(input logic [5:0] sec);
    return {2'(sec / 6'd10), 4'(sec % 6'd10)};
  endfunction

  localparam logic [5:0] SPRAY_BCD = to_bcd(6'(SPRAY_TIME));
  localparam logic [5:0] DRIP_BCD  = to_bcd(6'(DRIP_TIME));
  localparam logic [5:0] PAUSE_BCD = to_bcd(6'(PAUSE_TIME));

  state_e           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       active_zone_q, active_zone_d;
  logic [5:0]       timer_preset_q, timer_preset_d;
  logic             timer_load_q, timer_load_d;
  logic             cycle_done_q, cycle_done_d;
  logic [ZONES-1:0] valve_q, valve_d;
  logic             done_q, done_d;

  logic       done_rise;
  logic       stop_water;
  logic       grant_found;
  logic [1:0] grant_idx;

  // Only a fresh rising edge of time_over ends a phase; a level left high is stale.
  assign done_rise = timer_done & ~done_q;
  assign done_d    = timer_done;

`ifdef EARLY_STOP_EN
  assign stop_water = done_rise | ~zone_req[active_zone_q];
`else
  assign stop_water = done_rise;
`endif

  // Round-robin search starting just after the previously granted zone.
  always_comb begin : rr_search
    logic [1:0] cand;
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    for (int i = 1; i <= ZONES; i++) begin
      cand = 2'((int'(last_grant_q) + i) % ZONES);
      if (!grant_found && zone_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    active_zone_d  = active_zone_q;
    timer_preset_d = timer_preset_q;
    timer_load_d   = 1'b0;
    cycle_done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && grant_found) begin
          active_zone_d  = grant_idx;
          last_grant_d   = grant_idx;
          timer_preset_d = zone_drip[grant_idx] ? DRIP_BCD : SPRAY_BCD;
          timer_load_d   = 1'b1;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = enable ? S_WATER : S_IDLE;
      end
      S_WATER: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (stop_water) begin
          timer_preset_d = PAUSE_BCD;
          timer_load_d   = 1'b1;
          state_d        = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (done_rise) begin
          cycle_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered valve drive: the async reset closes it without a clock edge.
    valve_d = (state_d == S_WATER) ? (ZONES'(1) << active_zone_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge _50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 2'(ZONES - 1);
      active_zone_q  <= 2'd0;
      timer_preset_q <= 6'd0;
      timer_load_q   <= 1'b0;
      cycle_done_q   <= 1'b0;
      valve_q        <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      active_zone_q  <= active_zone_d;
      timer_preset_q <= timer_preset_d;
      timer_load_q   <= timer_load_d;
      cycle_done_q   <= cycle_done_d;
      valve_q        <= valve_d;
      done_q         <= done_d;
    end
  end

  assign timer_load   = timer_load_q;
  assign timer_preset = timer_preset_q;
  assign valve        = valve_q;
  assign active_zone  = active_zone_q;
  assign state        = state_q;
  assign busy         = (state_q != S_IDLE);
  assign cycle_done   = cycle_done_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Self-checking bench for irrigation_zone_scheduler: directed scenarios plus
// randomized traffic compared against a behavioural model of the zone schedule.
module tb_irrigation_zone_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] zone_req;
  logic [3:0] zone_drip;
  logic       timer_done;
  logic       timer_load;
  logic [5:0] timer_preset;
  logic [3:0] valve;
  logic [1:0] active_zone;
  logic [1:0] state;
  logic       busy;
  logic       cycle_done;

  irrigation_zone_scheduler dut (
    ._50_MHz     (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .zone_req    (zone_req),
    .zone_drip   (zone_drip),
    .timer_done  (timer_done),
    .timer_load  (timer_load),
    .timer_preset(timer_preset),
    .valve       (valve),
    .active_zone (active_zone),
    .state       (state),
    .busy        (busy),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 load, 2 water, 3 pause.
  int         m_phase, m_last, m_active;
  int         m_preset;
  logic       m_load, m_cdone, m_done_prev;

  function automatic int bcd(input int s);
    return (s / 10) * 16 + (s % 10);
  endfunction

  // Rotate the request vector so the zone after 'last' sits at bit 0.
  function automatic int pick_rr(input logic [3:0] req, input int last);
    logic [7:0] sh;
    int         w;
    logic       found;
    sh    = {req, req} >> (last + 1);
    w     = 0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && sh[k]) begin
        found = 1'b1;
        w     = (last + 1 + k) % 4;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_phase     = 0;
    m_last      = 3;
    m_active    = 0;
    m_preset    = 0;
    m_load      = 1'b0;
    m_cdone     = 1'b0;
    m_done_prev = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] req, input logic [3:0] drip,
                            input logic td);
    logic rise, stop;
    rise        = td && !m_done_prev;
    m_done_prev = td;
    m_load      = 1'b0;
    m_cdone     = 1'b0;
    stop        = rise;
`ifdef EARLY_STOP_EN
    if (!req[m_active]) stop = 1'b1;
`endif
    if (m_phase == 0) begin
      if (en && req != 4'b0) begin
        m_active = pick_rr(req, m_last);
        m_last   = m_active;
        m_preset = bcd(drip[m_active] ? 15 : 30);
        m_load   = 1'b1;
        m_phase  = 1;
      end
    end else if (!en) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && stop) begin
      m_preset = bcd(5);
      m_load   = 1'b1;
      m_phase  = 3;
    end else if (m_phase == 3 && rise) begin
      m_cdone = 1'b1;
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    check("state", state, m_phase);
    check("valve", valve, (m_phase == 2) ? (32'd1 << m_active) : 32'd0);
    check("timer_load", timer_load, m_load);
    check("timer_preset", timer_preset, m_preset);
    check("active_zone", active_zone, m_active);
    check("busy", busy, m_phase != 0);
    check("cycle_done", cycle_done, m_cdone);
  endtask

  // Called at a falling edge: drive inputs, advance the model, compare at the next falling edge.
  task automatic tick(input logic en, input logic [3:0] req, input logic [3:0] drip,
                      input logic td);
    enable     = en;
    zone_req   = req;
    zone_drip  = drip;
    timer_done = td;
    model_step(en, req, drip, td);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_async_valve", valve, 0);
    check("rst_async_state", state, 0);
    enable     = 1'b0;
    zone_req   = '0;
    zone_drip  = '0;
    timer_done = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();
  endtask

  task automatic full_cycle(input logic [3:0] req, input int exp_zone, input string tag);
    tick(1'b1, req, 4'b0, 1'b0);
    check({tag, "_zone"}, active_zone, exp_zone);
    tick(1'b1, req, 4'b0, 1'b0);
    tick(1'b1, req, 4'b0, 1'b1);
    tick(1'b1, req, 4'b0, 1'b0);
    tick(1'b1, req, 4'b0, 1'b1);
    check({tag, "_cdone"}, cycle_done, 1);
  endtask

  initial begin
    int         cnt;
    logic       td;
    logic       en;
    logic [3:0] req;
    reset_n    = 1'b1;
    enable     = 1'b0;
    zone_req   = '0;
    zone_drip  = '0;
    timer_done = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_preset", timer_preset, 0);
    check("reset_load", timer_load, 0);

    // Single spray zone through a full water/pause cycle.
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    check("t1_state_load", state, 1);
    check("t1_load_pulse", timer_load, 1);
    check("t1_preset30", timer_preset, 6'b11_0000);
    check("t1_valve_closed", valve, 0);
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    check("t1_state_water", state, 2);
    check("t1_valve_open", valve, 4'b0001);
    check("t1_load_single", timer_load, 0);
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    tick(1'b1, 4'b0001, 4'b0, 1'b1);
    check("t1_state_pause", state, 3);
    check("t1_preset5", timer_preset, 6'b00_0101);
    check("t1_pause_load", timer_load, 1);
    check("t1_pause_valve", valve, 0);
    tick(1'b1, 4'b0001, 4'b0, 1'b1);
    check("t1_pause_hold", state, 3);
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    tick(1'b1, 4'b0001, 4'b0, 1'b1);
    check("t1_cycle_done", cycle_done, 1);
    check("t1_idle", state, 0);
    tick(1'b1, 4'b0000, 4'b0, 1'b0);
    check("t1_cdone_single", cycle_done, 0);

    // Round robin from reset: 0,1,2,3,0.
    @(negedge clk);
    do_reset();
    full_cycle(4'b1111, 0, "rr0");
    full_cycle(4'b1111, 1, "rr1");
    full_cycle(4'b1111, 2, "rr2");
    full_cycle(4'b1111, 3, "rr3");
    full_cycle(4'b1111, 0, "rr4");

    // Drip zone preset.
    tick(1'b1, 4'b0100, 4'b0100, 1'b0);
    check("drip_zone", active_zone, 2);
    check("drip_preset15", timer_preset, 6'b01_0101);
    tick(1'b1, 4'b0100, 4'b0100, 1'b0);
    tick(1'b1, 4'b0100, 4'b0100, 1'b1);
    tick(1'b1, 4'b0100, 4'b0100, 1'b0);
    tick(1'b1, 4'b0100, 4'b0100, 1'b1);

    // timer_done held high through LOAD and WATER is stale.
    tick(1'b1, 4'b0010, 4'b0, 1'b1);
    tick(1'b1, 4'b0010, 4'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'b0010, 4'b0, 1'b1);
      check("stale_hold_water", state, 2);
    end
    tick(1'b1, 4'b0010, 4'b0, 1'b0);
    tick(1'b1, 4'b0010, 4'b0, 1'b1);
    check("stale_then_rise", state, 3);
    tick(1'b1, 4'b0010, 4'b0, 1'b0);
    tick(1'b1, 4'b0010, 4'b0, 1'b1);

    // Enable dropped mid-WATER together with done_rise; zone 2 gets aborted.
    tick(1'b1, 4'b1111, 4'b0, 1'b0);
    check("abort_grant", active_zone, 2);
    tick(1'b1, 4'b1111, 4'b0, 1'b0);
    tick(1'b1, 4'b1111, 4'b0, 1'b0);
    tick(1'b0, 4'b1111, 4'b0, 1'b1);
    check("abort_idle", state, 0);
    check("abort_valve", valve, 0);
    check("abort_no_load", timer_load, 0);
    check("abort_no_cdone", cycle_done, 0);
    tick(1'b1, 4'b1111, 4'b0, 1'b0);
    check("abort_next_grant", active_zone, 3);
    tick(1'b1, 4'b1111, 4'b0, 1'b0);
    check("midwater_valve", valve, 4'b1000);

    // Reset asserted mid-WATER closes the valve asynchronously.
    do_reset();

`ifdef EARLY_STOP_EN
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    tick(1'b1, 4'b0001, 4'b0, 1'b0);
    tick(1'b1, 4'b0000, 4'b0, 1'b0);
    check("early_pause", state, 3);
    check("early_load", timer_load, 1);
    check("early_preset", timer_preset, 6'b00_0101);
    tick(1'b1, 4'b0000, 4'b0, 1'b1);
`endif

    // Randomized traffic with a bench-side countdown emulation.
    cnt = 0;
    td  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      en  = ($urandom_range(0, 19) != 0);
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'b0;
      if (m_load) begin
        cnt = $urandom_range(1, 6);
        td  = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) td = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        td = ~td;
      end
      tick(en, req, 4'($urandom), td);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
